// File: rtl/sram_dp_clr.sv
// Simple dual-port SRAM with byte-enable writes, registered reads and a
// sequential zero-fill that runs after reset and on request.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | normal operation, reads and writes accepted, busy = 0
// S_CLEAR | zero-filling one word per cycle from r_clr_cnt, busy = 1
module sram_dp_clr #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    output logic                      busy,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    input  logic                      re,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_idle;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_old_wr;
    logic [DATA_WIDTH-1:0] w_merged;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (clear) w_next_state = S_CLEAR;
            S_CLEAR: if (r_clr_cnt == LAST_ADDR) w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_idle  = (r_state == S_IDLE);
        busy    = ~w_idle;
        w_wr_en = w_idle & we;
        w_rd_en = w_idle & re;
    end

    // Fill pointer is zeroed on entry so every fill starts at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (w_idle) begin
            r_clr_cnt <= '0;
        end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    always_comb begin
        w_old_wr = r_mem[wr_addr];
        w_merged = w_old_wr;
        for (int i = 0; i < BYTES; i++) begin
            if (wr_be[i]) w_merged[8*i +: 8] = wr_data[8*i +: 8];
        end
    end

    // Single write port shared between user writes and the zero-fill.
    always_comb begin
        w_mem_we    = w_wr_en | ~w_idle;
        w_mem_addr  = w_idle ? wr_addr : r_clr_cnt;
        w_mem_wdata = w_idle ? w_merged : '0;
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= w_rd_en;
            if (w_rd_en) begin
                if ((RDW_MODE != 0) && w_wr_en && (wr_addr == rd_addr)) begin
                    rd_data <= w_merged;
                end else begin
                    rd_data <= r_mem[rd_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_dp_clr.sv
// Randomized scoreboard bench for sram_dp_clr (ADDR_WIDTH=4, DATA_WIDTH=16).
module tb_sram_dp_clr;
    localparam int RDW = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        busy;
    logic        we = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_be = '0;
    logic        re = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_valid;

    sram_dp_clr #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(16),
        .RDW_MODE(RDW),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .busy(busy),
        .we(we),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_be(wr_be),
        .re(re),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] d;
    } exp_t;

    exp_t        q[$];
    logic [15:0] model[16];
    int          m_busy = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [15:0] last = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: consumes expected read results as the DUT presents them.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_rd_valid", 32'(rd_valid), 32'd0);
            chk("rst_rd_data", 32'(rd_data), 32'd0);
            last = '0;
        end else if (q.size() > 0 && q[0].due == cyc) begin
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_data", 32'(rd_data), 32'(q[0].d));
            last = q[0].d;
            void'(q.pop_front());
        end else begin
            chk("rd_valid_idle", 32'(rd_valid), 32'd0);
            chk("rd_data_hold", 32'(rd_data), 32'(last));
        end
    end

    task automatic zero_model();
        for (int i = 0; i < 16; i++) model[i] = '0;
    endtask

    // One clock of stimulus; called #1 after a rising edge.
    task automatic step(input logic s_we, input logic [3:0] s_wa, input logic [15:0] s_wd,
                        input logic [1:0] s_be, input logic s_re, input logic [3:0] s_ra,
                        input logic s_clr);
        exp_t        e;
        logic [15:0] merged;
        we = s_we; wr_addr = s_wa; wr_data = s_wd; wr_be = s_be;
        re = s_re; rd_addr = s_ra; clear = s_clr;
        chk("busy", 32'(busy), (m_busy > 0) ? 32'd1 : 32'd0);
        if (m_busy > 0) begin
            m_busy--;
        end else begin
            merged = model[s_wa];
            for (int b = 0; b < 2; b++) if (s_be[b]) merged[8*b +: 8] = s_wd[8*b +: 8];
            if (s_re) begin
                e.due = cyc + 1;
                e.d   = (RDW != 0 && s_we && s_wa == s_ra) ? merged : model[s_ra];
                q.push_back(e);
            end
            if (s_we) model[s_wa] = merged;
            if (s_clr) begin
                m_busy = 16;
                zero_model();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 16'd0, 2'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic rand_step(input int clr_den);
        step(1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom),
             1'($urandom), 4'($urandom), ($urandom_range(clr_den - 1, 0) == 0) ? 1'b1 : 1'b0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) step(1'b0, 4'd0, 16'd0, 2'd0, 1'b1, 4'(i), 1'b0);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_in_reset", 32'(busy), 32'd1);
        rst = 1'b0;
        m_busy = 16;
        zero_model();

        // Power-up fill with random traffic that must be ignored, then read back.
        for (int i = 0; i < 16; i++) rand_step(1000000);
        read_all();

        // Byte-enable merge and read-during-write.
        step(1'b1, 4'd3, 16'hA5C3, 2'b11, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd3, 16'h1200, 2'b10, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd5, 16'hFFFF, 2'b00, 1'b1, 4'd3, 1'b0);
        step(1'b1, 4'd7, 16'hBEEF, 2'b11, 1'b1, 4'd7, 1'b0);
        step(1'b0, 4'd0, 16'd0, 2'd0, 1'b1, 4'd7, 1'b0);
        step(1'b0, 4'd0, 16'd0, 2'd0, 1'b1, 4'd5, 1'b0);

        // Sparse reads: data must hold between them.
        step(1'b0, 4'd0, 16'd0, 2'd0, 1'b1, 4'd3, 1'b0);
        idle(1);
        step(1'b0, 4'd0, 16'd0, 2'd0, 1'b1, 4'd7, 1'b0);
        idle(2);

        // Fill, clear with a same-cycle write, second clear during busy ignored.
        for (int i = 0; i < 16; i++)
            step(1'b1, 4'(i), 16'($urandom), 2'b11, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd9, 16'h5A5A, 2'b11, 1'b1, 4'd2, 1'b1);
        for (int i = 0; i < 4; i++) rand_step(1000000);
        step(1'b1, 4'd1, 16'h1111, 2'b11, 1'b1, 4'd1, 1'b1);
        for (int i = 0; i < 13; i++) rand_step(1000000);
        read_all();

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) rand_step(40);
        while (m_busy > 0) idle(1);
        idle(2);

        // Reset in the middle of a fill restarts it from scratch.
        step(1'b0, 4'd0, 16'd0, 2'd0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 8; i++) rand_step(1000000);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_busy = 16;
        zero_model();
        for (int i = 0; i < 16; i++) rand_step(1000000);
        read_all();
        idle(3);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
